// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU stage sequencer: mode/stage encodings
// and the UART start byte that arms instruction loading.
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STALL = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_EXEC  = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEREG  = 3'd4,
        ST_HALT      = 3'd5,
        ST_STEP_WAIT = 3'd6
    } stage_t;

    localparam logic [7:0] START_BYTE = 8'hAA;

    // WRITEREG is two cycles: commit on cycle 0, clear on cycle 1
    localparam logic [3:0] WB_LAST = 4'd1;

endpackage

// File: rtl/seq_lat_counter.sv
// Shared 4-bit stage latency counter: synchronous clear, counts up to a
// per-stage limit and saturates there, flags when the limit is reached.
module seq_lat_counter (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic [3:0] limit_i,
    output logic [3:0] cnt_o,
    output logic       at_limit_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != limit_i)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign at_limit_o = (cnt_q == limit_i);

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Mode machine (STALL/LOAD/EXEC) and registered stage-pulse sequencer for the
// multi-cycle core. Optional single-step pause after each instruction: SEQ_SINGLE_STEP_EN.
module cpu_stage_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned FETCH_LAT  = 0,
    parameter int unsigned DECODE_LAT = 0,
    parameter int unsigned EXEC_LAT   = 5,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       load_done,
    input  logic       ex_valid,
    input  logic       stop_req,
    input  logic       step,
    output logic [1:0] mode,
    output logic [2:0] stage,
    output logic       fd_en,
    output logic       de_en,
    output logic       em_en,
    output logic       mw_en,
    output logic       pc_en,
    output logic       wb_commit,
    output logic       wb_clear,
    output logic       halted
);

    localparam logic [3:0] FETCH_L  = 4'(FETCH_LAT);
    localparam logic [3:0] DECODE_L = 4'(DECODE_LAT);
    localparam logic [3:0] EXEC_L   = 4'(EXEC_LAT);
    localparam logic [3:0] MEM_L    = 4'(MEM_LAT);

    mode_t  mode_q, mode_d;
    stage_t stage_q, stage_d;
    logic   fd_en_q, fd_en_d, de_en_q, de_en_d, em_en_q, em_en_d;
    logic   mw_en_q, mw_en_d, wb_commit_q, wb_commit_d, wb_clear_q, wb_clear_d;
    logic   halted_q, halted_d;

    logic       cnt_clr, cnt_inc, at_limit;
    logic [3:0] cnt_limit;
    logic [3:0] lat_cnt_unused;

    seq_lat_counter u_lat_counter (
        .clk        (clk),
        .rstn       (rstn),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .limit_i    (cnt_limit),
        .cnt_o      (lat_cnt_unused),
        .at_limit_o (at_limit)
    );

`ifndef SEQ_SINGLE_STEP_EN
    logic step_unused;
    assign step_unused = step;
`endif

    always_comb begin
        mode_d      = mode_q;
        stage_d     = stage_q;
        cnt_clr     = 1'b1;
        cnt_inc     = 1'b0;
        cnt_limit   = 4'd0;
        fd_en_d     = 1'b0;
        de_en_d     = 1'b0;
        em_en_d     = 1'b0;
        mw_en_d     = 1'b0;
        wb_commit_d = 1'b0;
        wb_clear_d  = 1'b0;

        case (mode_q)
            MODE_STALL: if (rx_ready && (rx_data == START_BYTE)) mode_d = MODE_LOAD;
            MODE_LOAD:  if (load_done) mode_d = MODE_EXEC;
            default:    mode_d = mode_q;
        endcase

        if (mode_q != MODE_EXEC) begin
            stage_d = ST_FETCH;
        end else begin
            case (stage_q)
                ST_FETCH: begin
                    cnt_limit = FETCH_L;
                    if (at_limit) begin
                        fd_en_d = 1'b1;
                        stage_d = ST_DECODE;
                    end else begin
                        cnt_clr = 1'b0;
                        cnt_inc = 1'b1;
                    end
                end
                ST_DECODE: begin
                    cnt_limit = DECODE_L;
                    if (at_limit) begin
                        de_en_d = 1'b1;
                        stage_d = ST_EXECUTE;
                    end else begin
                        cnt_clr = 1'b0;
                        cnt_inc = 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    // Counter saturates at the limit, so waiting on ex_valid just holds it there
                    cnt_limit = EXEC_L;
                    if (at_limit && ex_valid) begin
                        em_en_d = 1'b1;
                        stage_d = ST_MEMORY;
                    end else begin
                        cnt_clr = 1'b0;
                        cnt_inc = 1'b1;
                    end
                end
                ST_MEMORY: begin
                    cnt_limit = MEM_L;
                    if (at_limit) begin
                        mw_en_d = 1'b1;
                        stage_d = ST_WRITEREG;
                    end else begin
                        cnt_clr = 1'b0;
                        cnt_inc = 1'b1;
                    end
                end
                ST_WRITEREG: begin
                    cnt_limit = WB_LAST;
                    if (!at_limit) begin
                        wb_commit_d = 1'b1;
                        cnt_clr     = 1'b0;
                        cnt_inc     = 1'b1;
                    end else begin
                        wb_clear_d = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
                        stage_d = stop_req ? ST_HALT : ST_STEP_WAIT;
`else
                        stage_d = stop_req ? ST_HALT : ST_FETCH;
`endif
                    end
                end
                ST_HALT: stage_d = ST_HALT;
`ifdef SEQ_SINGLE_STEP_EN
                ST_STEP_WAIT: if (step) stage_d = ST_FETCH;
`endif
                default: stage_d = ST_FETCH;
            endcase
        end

        halted_d = (stage_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode_q      <= MODE_STALL;
            stage_q     <= ST_FETCH;
            fd_en_q     <= 1'b0;
            de_en_q     <= 1'b0;
            em_en_q     <= 1'b0;
            mw_en_q     <= 1'b0;
            wb_commit_q <= 1'b0;
            wb_clear_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            stage_q     <= stage_d;
            fd_en_q     <= fd_en_d;
            de_en_q     <= de_en_d;
            em_en_q     <= em_en_d;
            mw_en_q     <= mw_en_d;
            wb_commit_q <= wb_commit_d;
            wb_clear_q  <= wb_clear_d;
            halted_q    <= halted_d;
        end
    end

    assign mode      = mode_q;
    assign stage     = stage_q;
    assign fd_en     = fd_en_q;
    assign de_en     = de_en_q;
    assign em_en     = em_en_q;
    assign mw_en     = mw_en_q;
    assign pc_en     = mw_en_q;
    assign wb_commit = wb_commit_q;
    assign wb_clear  = wb_clear_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Bench for cpu_stage_sequencer: expected pulse/stage timeline per instruction is
// derived from the stage latencies and the cycle at which ex_valid is raised.
module tb_cpu_stage_sequencer;

    localparam int FL = 0;
    localparam int DL = 0;
    localparam int EL = 5;
    localparam int ML = 1;
`ifdef SEQ_SINGLE_STEP_EN
    localparam bit STEPMODE = 1'b1;
`else
    localparam bit STEPMODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn, rx_ready, load_done, ex_valid, stop_req, step;
    logic [7:0] rx_data;
    logic [1:0] mode;
    logic [2:0] stage;
    logic       fd_en, de_en, em_en, mw_en, pc_en, wb_commit, wb_clear, halted;

    int cyc    = 0;
    int passed = 0;
    int total  = 0;
    int fails  = 0;

    cpu_stage_sequencer #(
        .FETCH_LAT (FL),
        .DECODE_LAT(DL),
        .EXEC_LAT  (EL),
        .MEM_LAT   (ML)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .load_done(load_done),
        .ex_valid (ex_valid),
        .stop_req (stop_req),
        .step     (step),
        .mode     (mode),
        .stage    (stage),
        .fd_en    (fd_en),
        .de_en    (de_en),
        .em_en    (em_en),
        .mw_en    (mw_en),
        .pc_en    (pc_en),
        .wb_commit(wb_commit),
        .wb_clear (wb_clear),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    wire [13:0] obs = {mode, stage, fd_en, de_en, em_en, mw_en, pc_en, wb_commit, wb_clear, halted};

    function automatic logic [13:0] ev(logic [1:0] m, logic [2:0] s, logic [6:0] p, logic h);
        return {m, s, p, h};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(string tag, logic [13:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    // Bring the sequencer from STALL into EXEC, exercising ignored inputs on the way
    task automatic start_exec();
        logic [7:0] b;
        rx_ready  = 1'b0;
        load_done = 1'b1;
        tick();
        chk("stall_ignores_load_done", ev(2'd0, 3'd0, 7'd0, 1'b0));
        load_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'h55 : 8'($urandom_range(0, 255));
            if (b == 8'hAA) b = 8'h55;
            rx_data  = b;
            rx_ready = 1'b1;
            tick();
            chk("junk_byte", ev(2'd0, 3'd0, 7'd0, 1'b0));
        end
        rx_data  = 8'hAA;
        tick();
        rx_ready = 1'b0;
        chk("start_byte", ev(2'd1, 3'd0, 7'd0, 1'b0));
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("load_ignores_rx", ev(2'd1, 3'd0, 7'd0, 1'b0));
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("enter_exec", ev(2'd2, 3'd0, 7'd0, 1'b0));
    endtask

    // One instruction from FETCH entry; returns early (EXECUTE, cnt=abort_at) when abort_at >= 0
    task automatic run_instr(input int rise_off, input bit stop, input int abort_at);
        int f, fd, de, rise, em, mw, cm, cl, k;
        logic [2:0] s;
        logic [6:0] p;
        f    = cyc;
        fd   = f + FL + 1;
        de   = fd + DL + 1;
        rise = de + EL + rise_off;
        em   = rise + 1;
        mw   = em + ML + 1;
        cm   = mw + 1;
        cl   = cm + 1;
        stop_req = stop;
        while (cyc < cl) begin
            if (abort_at >= 0 && cyc == de + abort_at) return;
            ex_valid  = (cyc >= rise);
            rx_ready  = 1'($urandom_range(0, 1));
            rx_data   = 8'hAA;
            load_done = 1'($urandom_range(0, 1));
            if (!STEPMODE) step = 1'($urandom_range(0, 1));
            tick();
            k = cyc;
            p = {k == fd, k == de, k == em, k == mw, k == mw, k == cm, k == cl};
            if (k < fd)      s = 3'd0;
            else if (k < de) s = 3'd1;
            else if (k < em) s = 3'd2;
            else if (k < mw) s = 3'd3;
            else if (k < cl) s = 3'd4;
            else             s = stop ? 3'd5 : (STEPMODE ? 3'd6 : 3'd0);
            chk("instr", ev(2'd2, s, p, (k == cl) && stop));
        end
        if (STEPMODE && !stop) begin
            step = 1'b0;
            repeat (50) begin
                ex_valid = 1'($urandom_range(0, 1));
                tick();
                chk("step_wait", ev(2'd2, 3'd6, 7'd0, 1'b0));
            end
            step = 1'b1;
            tick();
            step = 1'b0;
            chk("step_go", ev(2'd2, 3'd0, 7'd0, 1'b0));
        end
    endtask

    initial begin
        rstn = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; load_done = 1'b0;
        ex_valid = 1'b0; stop_req = 1'b0; step = 1'b0;
        tick();
        tick();
        chk("reset", ev(2'd0, 3'd0, 7'd0, 1'b0));
        rstn = 1'b1;

        start_exec();
        run_instr(0, 1'b0, -1);
        run_instr(0, 1'b0, -1);
        run_instr(20, 1'b0, -1);
        repeat (4) run_instr($urandom_range(0, 4), 1'b0, -1);

        // Reset while EXECUTE has counted to 3
        run_instr(0, 1'b0, 3);
        rstn = 1'b0;
        tick();
        chk("mid_exec_reset", ev(2'd0, 3'd0, 7'd0, 1'b0));
        rstn = 1'b1;
        rx_ready = 1'b0; load_done = 1'b0; stop_req = 1'b0;
        tick();
        chk("post_reset_stall", ev(2'd0, 3'd0, 7'd0, 1'b0));

        start_exec();
        run_instr(0, 1'b0, -1);
        run_instr($urandom_range(0, 3), 1'b1, -1);
        repeat (100) begin
            rx_ready  = 1'($urandom_range(0, 1));
            load_done = 1'($urandom_range(0, 1));
            ex_valid  = 1'($urandom_range(0, 1));
            step      = 1'($urandom_range(0, 1));
            stop_req  = 1'($urandom_range(0, 1));
            tick();
            chk("halt_hold", ev(2'd2, 3'd5, 7'd0, 1'b1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
